// File: rtl/delay_fifo_reader.sv
// delay_fifo_reader: first-word-fall-through elastic buffer that absorbs a non-stallable
// sample stream and hands it downstream over valid/ready, with fill level and sticky overflow.
module delay_fifo_reader #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     validIn,
  input  logic [WIDTH-1:0]         dataIn,
  input  logic                     ready,
  output logic                     validOut,
  output logic [WIDTH-1:0]         dataOut,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almostFull,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d, count_q, count_d;
  logic afull_q, afull_d, ovf_q, ovf_d;
  logic empty, full, push, pop;
  assign empty = wr_q == rd_q;
  assign full = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
  assign validOut = !empty;
  assign dataOut = mem[rd_q[AW-1:0]];
  assign count = count_q;
  assign almostFull = afull_q;
  assign overflow = ovf_q;
  assign pop = validOut && ready;
  // A full buffer still accepts a push when the same edge frees a slot.
  assign push = validIn && (!full || pop);
  always_comb begin
    wr_d = clear ? '0 : wr_q + (AW+1)'(push);
    rd_d = clear ? '0 : rd_q + (AW+1)'(pop);
    count_d = clear ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
    afull_d = count_d >= (AW+1)'(AFULL_LEVEL);
    ovf_d = !clear && (ovf_q || (validIn && !push));
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
      afull_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
      afull_q <= afull_d;
      ovf_q <= ovf_d;
    end
  end
  always_ff @(posedge clock) begin
    if (push && !clear) mem[wr_q[AW-1:0]] <= dataIn;
  end
endmodule
